// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding and
// default geometry.
package seq_addsub_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIGIT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        NEGATE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/seq_addsub_digit_adder.sv
// Combinational W-bit ripple adder built from a chain of full-adder cells.
// The cell is kept as its own module so it can be swapped for a library cell.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (ci & p);

endmodule

module digit_adder #(
    parameter int W = 2
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_chain
        fa_cell u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co = c[W];

endmodule

// File: rtl/seq_addsub.sv
// Digit-serial unsigned add/subtract with magnitude+sign result and a
// valid/ready handshake on both sides.
//
//   state  | meaning
//   IDLE   | waiting for a request, in_ready high
//   CALC   | one DIGIT slice of A +/- B per cycle, LSB first
//   NEGATE | A < B in sub mode: two's-complement the raw result, one slice per cycle
//   DONE   | result presented, held until out_ready
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             neg
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    if (WIDTH < 2) begin : g_width_chk
        $error("seq_addsub: WIDTH must be at least 2");
    end
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_digit_chk
        $error("seq_addsub: DIGIT must divide WIDTH");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             neg_q, neg_d;

    logic [DIGIT-1:0] slice_x, slice_y, slice_s;
    logic             slice_co;
    logic [CW-1:0]    cnt_inc;
    logic             cnt_co;
    logic             cnt_last;
    logic [WIDTH-1:0] res_shift;

    // Single slice adder; CALC and NEGATE only differ in what is muxed in.
    always_comb begin
        slice_x = a_q[DIGIT-1:0];
        slice_y = sub_q ? ~b_q[DIGIT-1:0] : b_q[DIGIT-1:0];
        if (state_q == NEGATE) begin
            slice_x = ~res_q[DIGIT-1:0];
            slice_y = '0;
        end
    end

    digit_adder #(.W(DIGIT)) u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    digit_adder #(.W(CW)) u_cnt_inc (
        .x  (cnt_q),
        .y  ({CW{1'b0}}),
        .ci (1'b1),
        .s  (cnt_inc),
        .co (cnt_co)
    );

    // A wrapped counter can never be reached in normal flow; treat it as terminal anyway.
    assign cnt_last  = (cnt_q == LAST_CNT) | cnt_co;
    assign res_shift = (res_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        neg_d   = neg_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end

            CALC: begin
                res_d   = res_shift;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice_co;
                cnt_d   = cnt_inc;
                if (cnt_last) begin
                    cnt_d = '0;
                    if (sub_q && !slice_co) begin
                        carry_d = 1'b1;
                        state_d = NEGATE;
                    end else begin
                        sum_d   = res_shift;
                        cout_d  = slice_co;
                        neg_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end

            NEGATE: begin
                res_d   = res_shift;
                carry_d = slice_co;
                cnt_d   = cnt_inc;
                if (cnt_last) begin
                    cnt_d   = '0;
                    sum_d   = res_shift;
                    cout_d  = 1'b0;
                    neg_d   = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub (WIDTH=8, DIGIT=2): directed cases,
// randomized operations against an arithmetic model, back-pressure and reset.
module tb_seq_addsub;

    localparam int W = 8;
    localparam int D = 2;
    localparam int N = W / D;
    localparam int BUDGET = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         neg;

    int vectors = 0;
    int miscompares = 0;

    seq_addsub #(.WIDTH(W), .DIGIT(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic msub, input logic mcin,
                         output logic [W-1:0] esum, output logic ecout,
                         output logic eneg, output int elat);
        int t;
        if (!msub) begin
            t     = int'(ma) + int'(mb) + int'(mcin);
            esum  = t[W-1:0];
            ecout = t[W];
            eneg  = 1'b0;
            elat  = N;
        end else if (ma >= mb) begin
            t     = int'(ma) - int'(mb);
            esum  = t[W-1:0];
            ecout = 1'b1;
            eneg  = 1'b0;
            elat  = N;
        end else begin
            t     = int'(mb) - int'(ma);
            esum  = t[W-1:0];
            ecout = 1'b0;
            eneg  = 1'b1;
            elat  = 2 * N;
        end
    endtask

    // Presents a request for one edge and leaves in_valid low afterwards.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isub, input logic icin);
        @(negedge clk);
        a = ia; b = ib; sub = isub; cin = icin; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid; lat = -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= BUDGET; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_checked(input string tag, input logic [W-1:0] ta,
                               input logic [W-1:0] tb, input logic tsub,
                               input logic tcin);
        logic [W-1:0] es;
        logic ec, en;
        int el, lat;
        model(ta, tb, tsub, tcin, es, ec, en, el);
        issue(ta, tb, tsub, tcin);
        wait_done(lat);
        vectors++;
        if (lat !== el) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected %0d", tag, lat, el);
        end
        vectors++;
        if ({sum, cout, neg} !== {es, ec, en}) begin
            miscompares++;
            $display("FAIL %s result: got sum=%h cout=%b neg=%b expected sum=%h cout=%b neg=%b",
                     tag, sum, cout, neg, es, ec, en);
        end
        handshake();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s release: got in_ready=%b out_valid=%b expected 1/0",
                     tag, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, sum, cout, neg} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b neg=%b expected 0/00/0/0",
                     out_valid, sum, cout, neg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        run_checked("add_f0_20", 8'hF0, 8'h20, 1'b0, 1'b1);
        run_checked("sub_05_03", 8'h05, 8'h03, 1'b1, 1'b1);
        run_checked("sub_03_05", 8'h03, 8'h05, 1'b1, 1'b0);
        run_checked("sub_80_80", 8'h80, 8'h80, 1'b1, 1'b0);
        run_checked("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 1'b1);
        run_checked("sub_00_ff", 8'h00, 8'hFF, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, es, prev_sum;
        logic rs, rc, ec, en, prev_cout, prev_neg;
        int el, lat;
        prev_sum = sum; prev_cout = cout; prev_neg = neg;
        for (int k = 0; k < 24; k++) begin
            ra = W'($urandom_range(0, 255));
            rb = (k % 5 == 0) ? ra : W'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            model(ra, rb, rs, rc, es, ec, en, el);
            issue(ra, rb, rs, rc);
            // Mid-calculation the previous result must still be visible.
            vectors++;
            if ({sum, cout, neg} !== {prev_sum, prev_cout, prev_neg}) begin
                miscompares++;
                $display("FAIL rand%0d hold: got sum=%h cout=%b neg=%b expected sum=%h cout=%b neg=%b",
                         k, sum, cout, neg, prev_sum, prev_cout, prev_neg);
            end
            // Input changes after accept must not matter.
            a = ~ra; b = ~rb; sub = ~rs; cin = ~rc;
            wait_done(lat);
            vectors++;
            if (lat !== el || {sum, cout, neg} !== {es, ec, en}) begin
                miscompares++;
                $display("FAIL rand%0d a=%h b=%h sub=%b cin=%b: got lat=%0d sum=%h cout=%b neg=%b expected lat=%0d sum=%h cout=%b neg=%b",
                         k, ra, rb, rs, rc, lat, sum, cout, neg, el, es, ec, en);
            end
            handshake();
            prev_sum = es; prev_cout = ec; prev_neg = en;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(8'h03, 8'h05, 1'b1, 1'b0);
        wait_done(lat);
        @(negedge clk);
        a = 8'h11; b = 8'h22; sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({out_valid, in_ready, sum, cout, neg} !== {1'b1, 1'b0, 8'h02, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL stall%0d: got valid=%b ready=%b sum=%h cout=%b neg=%b expected 1/0/02/0/1",
                         i, out_valid, in_ready, sum, cout, neg);
            end
        end
        in_valid = 1'b0;
        handshake();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: got in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(8'h10, 8'h01, 1'b0, 1'b0);
        wait_done(lat);
        // Request already pending during the handshake edge must not be taken on it.
        @(negedge clk);
        a = 8'h40; b = 8'h50; sub = 1'b1; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_no_accept: got in_ready=%b out_valid=%b expected 1/0",
                     in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat);
        vectors++;
        if (lat !== 2 * N || {sum, cout, neg} !== {8'h10, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_result: got lat=%0d sum=%h cout=%b neg=%b expected lat=%0d sum=10 cout=0 neg=1",
                     lat, sum, cout, neg, 2 * N);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        issue(8'hF0, 8'h20, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors++;
        if ({in_ready, out_valid, sum, neg, cout} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid: got ready=%b valid=%b sum=%h neg=%b cout=%b expected 1/0/00/0/0",
                     in_ready, out_valid, sum, neg, cout);
        end
        // The abandoned operation must not surface later.
        repeat (2 * N) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abandon: got out_valid=%b expected 0", out_valid);
        end
        run_checked("post_reset_add", 8'h01, 8'h01, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; the block SHALL reject WIDTH < 2 at elaboration.
REQ-002 Parameter DIGIT, default 2, bits processed per cycle; the block SHALL reject DIGIT that does not divide WIDTH at elaboration; N = WIDTH/DIGIT.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Ports SHALL be: in_valid input 1 (request); in_ready output 1 (block can accept); a input WIDTH (operand A, unsigned); b input WIDTH (operand B, unsigned); sub input 1 (1 = A-B, 0 = A+B); cin input 1 (carry-in, add mode only).
REQ-006 Ports SHALL be: out_valid output 1 (result available); out_ready input 1 (consumer takes result); sum output WIDTH (magnitude result); cout output 1 (carry out / no-borrow); neg output 1 (result negative).

Function
REQ-007 The FSM SHALL have states IDLE, CALC, NEGATE, DONE.
REQ-008 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready at a rising edge.
REQ-009 On accept, a, b, sub, cin SHALL be registered; later input changes SHALL NOT affect the operation.
REQ-010 On accept, the FSM SHALL enter CALC with the digit counter at 0 and carry = (sub ? 1 : cin).
REQ-011 CALC SHALL process one DIGIT-wide slice per cycle, LSB first: A slice + (sub ? ~B slice : B slice) + carry; the slice result SHALL go into the result register and carry-out into carry.
REQ-012 After N CALC cycles, the final carry SHALL be cout; add, or sub with final carry = 1, SHALL go to DONE with neg = 0.
REQ-013 Sub with final carry = 0 (A < B) SHALL go to NEGATE, set neg = 1 and cout = 0, and replace the result register with its two's complement over N cycles, one slice per cycle: ~slice + carry, carry initialised to 1.
REQ-014 out_valid SHALL be 1 only in DONE; for add or sub with A >= B it SHALL rise N edges after the accept edge; for sub with A < B, 2N edges after.
REQ-015 sum, cout, neg SHALL be stable throughout DONE; in add mode sum = (A+B+cin) mod 2^WIDTH and cout = bit WIDTH.
REQ-016 In sub mode sum SHALL be |A-B|, cin SHALL be ignored, and A == B SHALL give sum 0, neg 0, cout 1.
REQ-017 In DONE, out_valid & out_ready at an edge SHALL return the FSM to IDLE; no accept SHALL occur on that same edge.
REQ-018 While out_ready = 0 in DONE, all outputs SHALL hold and in_valid SHALL be ignored.
REQ-019 sum, cout, neg SHALL be registered outputs and keep their last values in IDLE and CALC until overwritten by the next completion.

Reset
REQ-020 rst_n = 0 at a rising edge SHALL force IDLE, counter 0, carry 0, sum 0, cout 0, neg 0, out_valid 0.
REQ-021 in_ready SHALL be 1 from the first cycle after the reset edge with rst_n = 1.
REQ-022 Reset during CALC, NEGATE or DONE SHALL abandon the operation with no result emitted.

Structure
REQ-023 Package seq_addsub_pkg SHALL hold the state encoding constants (IDLE, CALC, NEGATE, DONE) and default WIDTH/DIGIT values.
REQ-024 The combinational slice adder SHALL be a sub-module digit_adder (DIGIT-bit ripple chain of the team's full-adder cell), shared by CALC and NEGATE through operand muxing.
REQ-025 The counter SHALL be $clog2(N)+1 bits wide; no other arithmetic SHALL exist outside digit_adder.

Verification (WIDTH=8, DIGIT=2, N=4)
REQ-026 add a=0xF0, b=0x20, cin=1 -> out_valid 4 edges after accept, sum=0x11, cout=1, neg=0.
REQ-027 sub a=0x05, b=0x03, cin=1 -> 4 edges, sum=0x02, cout=1, neg=0 (cin ignored).
REQ-028 sub a=0x03, b=0x05 -> 8 edges, sum=0x02, cout=0, neg=1; sub a=0x80, b=0x80 -> 4 edges, sum=0x00, cout=1, neg=0.
REQ-029 out_ready held 0 for 3 cycles in DONE while in_valid=1 with new operands -> outputs unchanged, in_ready=0, no accept; in_ready=1 the cycle after the out_ready handshake.
REQ-030 rst_n=0 for one edge at CALC cycle 2 -> next cycle in_ready=1, out_valid=0, sum=0x00, neg=0, cout=0; a subsequent add 0x01+0x01 completes normally with sum=0x02.
